// File: rtl/etapa4_memoria.sv
// Purpose : MEM pipeline stage. Word-addressed data memory with LATENCY wait states,
//           producing one registered write-back record per completed instruction.
// Latency : non-memory ops 1 edge; aligned loads/stores LATENCY edges (LATENCY-1 stall cycles).
// Backpr. : stall is combinational from ex_* and cnt; upstream holds ex_* while stall=1.
// Ports   : clk/reset (async, active-high); ex_* instruction from execute; stall to upstream;
//           wb_* registered write-back record; addr_error misalignment pulse; stall_count.
module etapa4_memoria #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_reg_write,
    input  logic        ex_mem_to_reg,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_store_data,
    input  logic [4:0]  ex_write_reg,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [4:0]  wb_write_reg,
    output logic [31:0] wb_write_data,
    output logic        addr_error,
    output logic [31:0] stall_count
);
    localparam int              CW   = 4;
    localparam logic [CW-1:0]   LAST = CW'(LATENCY - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [31:0]           mem [0:(1 << DEPTH_LOG2) - 1];

    logic                  mem_op;
    logic                  aligned;
    logic                  access;
    logic                  misaligned;
    logic                  complete;
    logic                  is_load;
    logic [DEPTH_LOG2-1:0] index;
    logic [31:0]           rd_word;

    assign mem_op     = ex_valid & (ex_mem_read | ex_mem_write);
    assign aligned    = (ex_alu_result[1:0] == 2'b00);
    assign access     = mem_op & aligned;
    assign misaligned = mem_op & ~aligned;
    // A store with mem_read also set is still a store and performs no read.
    assign is_load    = ex_mem_read & ~ex_mem_write;
    // Upper address bits are dropped on purpose, so addresses alias around the memory.
    assign index      = ex_alu_result[DEPTH_LOG2+1:2];
    assign rd_word    = mem[index];

    assign stall      = access & (cnt != LAST);
    assign complete   = access & ~stall;

    // Memory is deliberately outside the reset domain: contents survive reset.
    // A store only commits on its completion edge, so a reset mid-wait drops it.
    always_ff @(posedge clk) begin
        if (complete && ex_mem_write) begin
            mem[index] <= ex_store_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_write_reg  <= '0;
            wb_write_data <= '0;
            addr_error    <= 1'b0;
            stall_count   <= '0;
        end else begin
            addr_error <= 1'b0;
            if (stall) begin
                // Wait state: emit a bubble and advance the wait counter.
                state        <= WAIT;
                cnt          <= (state == IDLE) ? CW'(1) : cnt + 1'b1;
                stall_count  <= stall_count + 32'd1;
                wb_valid     <= 1'b0;
                wb_reg_write <= 1'b0;
            end else begin
                state <= IDLE;
                cnt   <= '0;
                if (!ex_valid) begin
                    // Bubble: record index and data are kept as they were.
                    wb_valid     <= 1'b0;
                    wb_reg_write <= 1'b0;
                end else if (misaligned) begin
                    wb_valid      <= 1'b1;
                    wb_reg_write  <= 1'b0;
                    wb_write_reg  <= ex_write_reg;
                    wb_write_data <= ex_alu_result;
                    addr_error    <= 1'b1;
                end else begin
                    // Completion of an aligned access or of a non-memory instruction.
                    wb_valid      <= 1'b1;
                    wb_reg_write  <= ex_reg_write & ~ex_mem_write & (ex_write_reg != 5'd0);
                    wb_write_reg  <= ex_write_reg;
                    wb_write_data <= (ex_mem_to_reg && access && is_load) ? rd_word : ex_alu_result;
                end
            end
        end
    end
endmodule

// File: tb/tb_etapa4_memoria.sv
module tb_etapa4_memoria;
    logic        clk = 1'b0;
    logic        reset2, reset4;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_write_reg;

    logic        stall2, wb_valid2, wb_reg_write2, addr_error2;
    logic [4:0]  wb_write_reg2;
    logic [31:0] wb_write_data2, stall_count2;
    logic        stall4, wb_valid4, wb_reg_write4, addr_error4;
    logic [4:0]  wb_write_reg4;
    logic [31:0] wb_write_data4, stall_count4;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    etapa4_memoria #(.DEPTH_LOG2(8), .LATENCY(2)) dut2 (
        .clk(clk), .reset(reset2), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .stall(stall2), .wb_valid(wb_valid2), .wb_reg_write(wb_reg_write2),
        .wb_write_reg(wb_write_reg2), .wb_write_data(wb_write_data2),
        .addr_error(addr_error2), .stall_count(stall_count2)
    );

    etapa4_memoria #(.DEPTH_LOG2(8), .LATENCY(4)) dut4 (
        .clk(clk), .reset(reset4), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_write_reg(ex_write_reg),
        .stall(stall4), .wb_valid(wb_valid4), .wb_reg_write(wb_reg_write4),
        .wb_write_reg(wb_write_reg4), .wb_write_data(wb_write_data4),
        .addr_error(addr_error4), .stall_count(stall_count4)
    );

    typedef struct {
        logic        rd, wr, rw, m2r;
        logic [31:0] alu, sd;
        logic [4:0]  rg;
        int          stalls;
        logic        exp_rw;
        logic [31:0] exp_data;
        logic        data_dc;
        logic        exp_ae;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  rg;
        logic [31:0] data;
        logic        data_dc;
        logic        ae;
    } exp_t;

    vec_t tbl [12];
    exp_t sb [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic rw, input logic m2r,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rg);
        ex_valid      = 1'b1;
        ex_mem_read   = rd;
        ex_mem_write  = wr;
        ex_reg_write  = rw;
        ex_mem_to_reg = m2r;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_write_reg  = rg;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0);
        ex_valid = 1'b0;
    endtask

    // Count stall cycles of the selected instance until it lets the instruction go.
    task automatic count_stalls(input bit use4, output int n);
        n = 0;
        #1;
        while ((use4 ? stall4 : stall2) && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    // Scoreboard consumer for the LATENCY=2 instance.
    always @(negedge clk) begin
        if (mon_en) begin
            if (wb_valid2) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wb actual=wb_valid required=no_record");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_reg_write", {31'd0, wb_reg_write2}, {31'd0, e.rw});
                    chk("addr_error", {31'd0, addr_error2}, {31'd0, e.ae});
                    if (!e.ae) chk("wb_write_reg", {27'd0, wb_write_reg2}, {27'd0, e.rg});
                    if (!e.data_dc) chk("wb_write_data", wb_write_data2, e.data);
                end
            end else begin
                chk("addr_error_idle", {31'd0, addr_error2}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int total_stalls;

        tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd21,       32'd0,          5'd3,  0, 1'b1, 32'd21,         1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h10,       32'hDEADBEEF,   5'd0,  1, 1'b0, 32'h10,         1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10,       32'd0,          5'd8,  1, 1'b1, 32'hDEADBEEF,   1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h13,       32'd0,          5'd9,  0, 1'b0, 32'd0,          1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10,       32'd0,          5'd0,  1, 1'b0, 32'hDEADBEEF,   1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h400,      32'd7,          5'd0,  1, 1'b0, 32'h400,        1'b0, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h000,      32'd0,          5'd4,  1, 1'b1, 32'd7,          1'b0, 1'b0};
        tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h8,        32'h55,         5'd5,  1, 1'b0, 32'd0,          1'b1, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8,        32'd0,          5'd10, 1, 1'b1, 32'h55,         1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h402,      32'h99,         5'd0,  0, 1'b0, 32'd0,          1'b1, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h400,      32'd0,          5'd11, 1, 1'b1, 32'd7,          1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h77,       32'd0,          5'd0,  0, 1'b0, 32'h77,         1'b0, 1'b0};

        // Reset held for two cycles with an access presented.
        reset2 = 1'b1;
        reset4 = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 32'd0, 5'd8);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid2}, 32'd0);
        chk("rst_wb_reg_write", {31'd0, wb_reg_write2}, 32'd0);
        chk("rst_wb_write_reg", {27'd0, wb_write_reg2}, 32'd0);
        chk("rst_wb_write_data", wb_write_data2, 32'd0);
        chk("rst_addr_error", {31'd0, addr_error2}, 32'd0);
        chk("rst_stall_count", stall_count2, 32'd0);
        chk("rst_cnt", {28'd0, dut2.cnt}, 32'd0);
        chk("rst4_cnt", {28'd0, dut4.cnt}, 32'd0);
        chk("rst4_stall_count", stall_count4, 32'd0);

        // Phase 1: LATENCY=2 table through the scoreboard.
        idle_inputs();
        reset2 = 1'b0;
        mon_en = 1'b1;
        total_stalls = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(tbl[i].rd, tbl[i].wr, tbl[i].rw, tbl[i].m2r, tbl[i].alu, tbl[i].sd, tbl[i].rg);
            count_stalls(1'b0, n);
            chk($sformatf("stall_cycles_%0d", i), n, tbl[i].stalls);
            total_stalls += tbl[i].stalls;
            if (i == 2) chk("stall_count_after_st_ld", stall_count2, 32'd2);
            sb.push_back('{tbl[i].exp_rw, tbl[i].rg, tbl[i].exp_data, tbl[i].data_dc, tbl[i].exp_ae});
            @(posedge clk);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        mon_en = 1'b0;
        // Bubble: valid drops, record index/data hold their last values.
        chk("bubble_wb_valid", {31'd0, wb_valid2}, 32'd0);
        chk("bubble_wb_reg_write", {31'd0, wb_reg_write2}, 32'd0);
        chk("bubble_hold_reg", {27'd0, wb_write_reg2}, 32'd0);
        chk("bubble_hold_data", wb_write_data2, 32'h77);
        chk("total_stall_count", stall_count2, total_stalls);
        chk("scoreboard_drained", sb.size(), 32'd0);

        // Phase 2: LATENCY=4, reset in the middle of a store.
        reset2 = 1'b1;
        reset4 = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'd9, 5'd0);
        count_stalls(1'b1, n);
        chk("l4_first_store_stalls", n, 3);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'd5, 5'd0);
        #1;
        chk("l4_store_stall", {31'd0, stall4}, 32'd1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("l4_cnt_before_reset", {28'd0, dut4.cnt}, 32'd2);
        reset4 = 1'b1;
        idle_inputs();
        #1;
        chk("l4_stall_after_reset", {31'd0, stall4}, 32'd0);
        chk("l4_cnt_after_reset", {28'd0, dut4.cnt}, 32'd0);
        @(negedge clk);
        reset4 = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 32'd0, 5'd6);
        count_stalls(1'b1, n);
        chk("l4_load_stalls", n, 3);
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        chk("l4_wb_valid", {31'd0, wb_valid4}, 32'd1);
        chk("l4_wb_reg_write", {31'd0, wb_reg_write4}, 32'd1);
        chk("l4_wb_write_reg", {27'd0, wb_write_reg4}, 32'd6);
        chk("l4_old_value_kept", wb_write_data4, 32'd9);
        chk("l4_stall_count", stall_count4, 32'd3);
        chk("l4_addr_error", {31'd0, addr_error4}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
